// File: rtl/weight_bank_streamer.sv
// Multi-lane weight store: NUM_CH block-RAM banks with a host load port and a burst
// sequencer that streams a wrapping address window under valid/ready flow control.
module weight_bank_streamer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 28,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned LEN_W  = ADDR_W + 1,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [CH_W-1:0]          wch_i,
  input  logic [DATA_W-1:0]        di_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_i,
  input  logic [LEN_W-1:0]         len_i,
  output logic [NUM_CH*DATA_W-1:0] do_o,
  output logic                     do_valid_o,
  input  logic                     do_ready_i,
  output logic                     do_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     wr_err_o
);

  localparam int unsigned BEAT_W = NUM_CH * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic                busy_q, done_q, wr_err_q;
  logic                rd_valid_q, rd_last_q;
  logic [BEAT_W-1:0]   out_q, skid_q;
  logic                out_valid_q, out_last_q, skid_valid_q, skid_last_q;
  logic [BEAT_W-1:0]   rd_data;

  logic                idle, wr_bad, wr_en, pop, issue;
  logic [1:0]          occupancy;
  logic [ADDR_W-1:0]   base_mod, addr_next;

  always_comb begin
    idle      = (state_q == StIdle);
    wr_bad    = we_i && (!idle || (waddr_i > LAST_ADDR));
    wr_en     = we_i && !wr_bad;
    pop       = out_valid_q && do_ready_i;
    // Entries held or in flight once this cycle's beat leaves; the read issued now lands
    // next cycle, so issue only while at most one slot is spoken for.
    occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_valid_q}
              - {1'b0, pop};
    issue     = (state_q == StStream) && (occupancy < 2'd2);
    base_mod  = (base_i > LAST_ADDR) ? base_i - DEPTH_A : base_i;
    addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    logic [DATA_W-1:0] bank_q [DEPTH];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (wr_en && (wch_i == CH_W'(g))) begin
        bank_q[waddr_i] <= di_i;
      end
      if (issue) begin
        rd_q <= bank_q[addr_q];
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = rd_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rem_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= issue;
      if (wr_bad) begin
        wr_err_q <= 1'b1;
      end
      if (issue) begin
        rd_last_q <= (rem_q == LEN_ONE);
      end

      // Two-entry buffer: the output register always holds the oldest beat.
      if (!out_valid_q || pop) begin
        if (skid_valid_q) begin
          out_q        <= skid_q;
          out_last_q   <= skid_last_q;
          out_valid_q  <= 1'b1;
          skid_q       <= rd_data;
          skid_last_q  <= rd_last_q;
          skid_valid_q <= rd_valid_q;
        end else begin
          out_valid_q <= rd_valid_q;
          if (rd_valid_q) begin
            out_q      <= rd_data;
            out_last_q <= rd_last_q;
          end
        end
      end else if (rd_valid_q) begin
        skid_q       <= rd_data;
        skid_last_q  <= rd_last_q;
        skid_valid_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (len_i != '0) begin
              addr_q  <= base_mod;
              rem_q   <= len_i;
              busy_q  <= 1'b1;
              state_q <= StStream;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StStream: begin
          if (issue) begin
            addr_q <= addr_next;
            rem_q  <= rem_q - LEN_ONE;
            if (rem_q == LEN_ONE) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && out_last_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign do_o       = out_q;
  assign do_valid_o = out_valid_q;
  assign do_last_o  = out_last_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_err_o   = wr_err_q;

endmodule

// File: tb/tb_weight_bank_streamer.sv
// Randomized bench for weight_bank_streamer: a queue-based model of memory and bursts is
// checked against the DUT every cycle, plus literal checks on known data patterns.
module tb_weight_bank_streamer;

  localparam int DEPTH  = 28;
  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [1:0]  wch = '0;
  logic [15:0] di = '0;
  logic        start = 1'b0;
  logic [4:0]  base = '0;
  logic [5:0]  len = '0;
  logic [63:0] dout;
  logic        do_valid, do_last, busy, done, wr_err;
  logic        do_ready = 1'b1;

  weight_bank_streamer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (we),
    .waddr_i    (waddr),
    .wch_i      (wch),
    .di_i       (di),
    .start_i    (start),
    .base_i     (base),
    .len_i      (len),
    .do_o       (dout),
    .do_valid_o (do_valid),
    .do_ready_i (do_ready),
    .do_last_o  (do_last),
    .busy_o     (busy),
    .done_o     (done),
    .wr_err_o   (wr_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] lane(logic [63:0] w, int c);
    return w[c*16 +: 16];
  endfunction

  // Behavioural model: memory image, queue of expected beats, sticky error flag.
  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] acc_log[$];
  logic [15:0] mm [NUM_CH][DEPTH];
  bit          m_busy = 1'b0;
  bit          m_err = 1'b0;
  bit          done_due = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_do;
  logic        prev_last;

  initial begin
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < DEPTH; a++) mm[c][a] = '0;
  end

  always @(negedge clk) begin : cmp
    bit    busy_now, done_next;
    beat_t e;
    int    a;
    if (rst) begin
      exp_q.delete();
      m_busy     = 1'b0;
      m_err      = 1'b0;
      done_due   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      busy_now  = m_busy;
      done_next = 1'b0;
      chk("busy", busy, m_busy);
      chk("wr_err", wr_err, m_err);
      chk("done", done, done_due);
      if (!m_busy) chk("valid_when_idle", do_valid, 0);
      if (prev_stall) begin
        chk("stall_valid", do_valid, 1);
        chk("stall_data", dout, prev_do);
        chk("stall_last", do_last, prev_last);
      end
      if (do_valid && do_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_beat: got beat %h, expected no beat", dout);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", dout, e.data);
          chk("beat_last", do_last, e.last);
          acc_log.push_back(dout);
          if (e.last) begin
            m_busy    = 1'b0;
            done_next = 1'b1;
          end
        end
      end
      prev_stall = do_valid && !do_ready;
      prev_do    = dout;
      prev_last  = do_last;
      // Load lands before a same-cycle burst start reads memory.
      if (we) begin
        if (busy_now || int'(waddr) >= DEPTH) m_err = 1'b1;
        else mm[wch][waddr] = di;
      end
      if (start && !busy_now) begin
        if (len == 0) begin
          done_next = 1'b1;
        end else begin
          for (int i = 0; i < int'(len); i++) begin
            a = (int'(base) + i) % DEPTH;
            for (int c = 0; c < NUM_CH; c++) e.data[c*16 +: 16] = mm[c][a];
            e.last = (i == int'(len) - 1);
            exp_q.push_back(e);
          end
          m_busy = 1'b1;
        end
      end
      done_due = done_next;
    end
  end

  // Consumer: 0 = always ready, 1 = random, 2 = fixed toggle pattern.
  int rmode = 0;
  int pidx = 0;
  bit pat [6] = '{1, 0, 0, 1, 0, 1};

  always @(posedge clk) begin
    #1;
    case (rmode)
      1: do_ready = 1'($urandom_range(0, 1));
      2: begin
        do_ready = pat[pidx];
        pidx = (pidx + 1) % 6;
      end
      default: begin
        do_ready = 1'b1;
        pidx = 0;
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int ch, int a, logic [15:0] d);
    we = 1'b1;
    wch = 2'(ch);
    waddr = 5'(a);
    di = d;
    tick();
    we = 1'b0;
  endtask

  task automatic start_burst(int b, int l);
    start = 1'b1;
    base = 5'(b);
    len = 6'(l);
    tick();
    start = 1'b0;
  endtask

  // Returns just after the edge that accepts the final beat.
  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 800) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (m_busy) begin
      vectors++;
      miscompares++;
      $display("FAIL burst_timeout: still busy after %0d cycles, expected idle", n);
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    tick();
  endtask

  initial begin
    int n, b, l, k;
    repeat (2) tick();
    chk("rst_do", dout, 0);
    chk("rst_valid", do_valid, 0);
    chk("rst_last", do_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
    rst = 1'b0;
    tick();

    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < DEPTH; a++) load(c, a, 16'(c * 100 + a));

    // Full-depth burst with latency checks.
    acc_log.delete();
    start_burst(0, 28);
    @(negedge clk); chk("lat_edge_k", do_valid, 0);
    @(negedge clk); chk("lat_edge_k1", do_valid, 0);
    @(negedge clk); chk("lat_edge_k2", do_valid, 1);
    chk("lat_first_word", lane(dout, 0), 16'd0);
    wait_idle();
    chk("t1_done_pulse", done, 1);
    chk("t1_beats", acc_log.size(), 28);
    chk("t1_beat5_lane2", lane(acc_log[5], 2), 16'd205);
    chk("t1_beat27_lane0", lane(acc_log[27], 0), 16'd27);
    tick();
    chk("t1_done_single", done, 0);

    // Wrap-around window.
    acc_log.delete();
    start_burst(26, 4);
    wait_idle();
    chk("t2_b0", lane(acc_log[0], 0), 16'd26);
    chk("t2_b1", lane(acc_log[1], 0), 16'd27);
    chk("t2_b2", lane(acc_log[2], 0), 16'd0);
    chk("t2_b3", lane(acc_log[3], 0), 16'd1);
    chk("t2_b2_lane3", lane(acc_log[2], 3), 16'd300);

    // Backpressure pattern.
    rmode = 2;
    acc_log.delete();
    start_burst(10, 6);
    wait_idle();
    rmode = 0;
    chk("t3_beats", acc_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_order", lane(acc_log[i], 0), 16'(10 + i));

    // Load then read back.
    load(3, 7, 16'hFFFB);
    acc_log.delete();
    start_burst(7, 1);
    wait_idle();
    chk("t4_lane3", lane(acc_log[0], 3), 16'hFFFB);
    chk("t4_lane0", lane(acc_log[0], 0), 16'd7);
    chk("t4_lane1", lane(acc_log[0], 1), 16'd107);
    chk("t4_lane2", lane(acc_log[0], 2), 16'd207);

    // Load and START while busy are both dropped.
    rmode = 1;
    start_burst(0, 8);
    we = 1'b1; wch = 2'd1; waddr = 5'd2; di = 16'h1234;
    start = 1'b1; base = 5'd20; len = 6'd3;
    tick();
    we = 1'b0;
    start = 1'b0;
    wait_idle();
    rmode = 0;
    chk("t5_wr_err", wr_err, 1);
    acc_log.delete();
    start_burst(2, 1);
    wait_idle();
    chk("t5_mem_kept", lane(acc_log[0], 1), 16'd102);
    chk("t5_no_extra", acc_log.size(), 1);
    start_burst(0, 0);
    chk("t5_len0_done", done, 1);
    chk("t5_len0_valid", do_valid, 0);
    tick();
    chk("t5_len0_done_off", done, 0);

    // Reset mid-burst.
    acc_log.delete();
    start_burst(0, 10);
    n = 0;
    while (acc_log.size() < 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", do_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", wr_err, 0);
    tick();
    rst = 1'b0;
    acc_log.delete();
    start_burst(0, 2);
    wait_idle();
    chk("t6_b0_lane0", lane(acc_log[0], 0), 16'd0);
    chk("t6_b1_lane1", lane(acc_log[1], 1), 16'd101);

    // Out-of-range load.
    load(0, 30, 16'h7777);
    chk("oob_wr_err", wr_err, 1);

    // Randomized bursts, loads and busy-time pokes.
    for (int r = 0; r < 40; r++) begin
      rmode = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 2));
      for (int j = 0; j < k; j++)
        load(int'($urandom_range(0, 3)), int'($urandom_range(0, 29)), 16'($urandom));
      b = int'($urandom_range(0, 31));
      l = int'($urandom_range(0, 32));
      if ($urandom_range(0, 3) == 0) begin
        we = 1'b1;
        wch = 2'($urandom);
        waddr = 5'($urandom_range(0, 27));
        di = 16'($urandom);
      end
      start_burst(b, l);
      we = 1'b0;
      if (l >= 4 && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        base = 5'($urandom);
        len = 6'($urandom_range(1, 20));
        we = 1'b1;
        wch = 2'($urandom);
        waddr = 5'($urandom_range(0, 27));
        di = 16'($urandom);
        tick();
        start = 1'b0;
        we = 1'b0;
      end
      wait_idle();
    end
    rmode = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
